conv_test_controller: RTL

Sequences self-test runs of the convolution datapath. Pulses the test-vector generator's `next_test`, watches the generator-to-conv `valid`/`ready` handshake, and accepts each conv result. Compares every result against a golden ROM and reports pass/fail with an error count and a watchdog timeout flag. Sits beside the data generator and the conv unit in the top-level test harness.

---
 rtl/conv_test_controller.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/conv_test_controller.sv
// Self-test sequencer for the conv datapath: issues vectors, checks results vs golden ROM.
// Latency: next_test one cycle after start; per-test minimum 3 cycles; all outputs registered except result_ready.
// Backpressure: waits on the generator valid/ready and on result_valid; a watchdog aborts a stalled run.
module conv_test_controller #(
  parameter int NUM_TESTS = 8,
  parameter int RESULT_W  = 128,
  parameter int TIMEOUT   = 1023
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                start,
  output logic                next_test,
  input  logic                in_valid,
  input  logic                in_ready,
  input  logic                result_valid,
  input  logic [RESULT_W-1:0] result_data,
  output logic                result_ready,
  output logic [2:0]          exp_index,
  input  logic [RESULT_W-1:0] exp_data,
  output logic [2:0]          test_index,
  output logic [3:0]          err_count,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic                timeout_err
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE        = 3'd0;
  localparam logic [2:0] S_ISSUE       = 3'd1;
  localparam logic [2:0] S_WAIT_ACCEPT = 3'd2;
  localparam logic [2:0] S_WAIT_RESULT = 3'd3;
  localparam logic [2:0] S_DONE        = 3'd4;

  localparam logic [2:0]      LAST_IDX = 3'(NUM_TESTS - 1);
  // The watchdog reaches TIMEOUT on the edge that declares the timeout.
  localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT - 1);

  logic [2:0]      state;
  logic [WD_W-1:0] wd;
  logic [2:0]      vec_ptr;

  logic            in_wait;
  logic            accept_hs;
  logic            result_hs;
  logic            wd_expire;
  logic            mismatch;
  logic [3:0]      err_inc;

  assign in_wait      = (state == S_WAIT_ACCEPT) || (state == S_WAIT_RESULT);
  assign accept_hs    = (state == S_WAIT_ACCEPT) && in_valid && in_ready;
  assign result_hs    = (state == S_WAIT_RESULT) && result_valid;
  // A handshake landing on the final watchdog cycle wins over the timeout.
  assign wd_expire    = in_wait && (wd == WD_LAST) && !accept_hs && !result_hs;
  assign mismatch     = (result_data != exp_data);
  assign err_inc      = (err_count == 4'hF) ? 4'hF : err_count + 4'd1;

  assign result_ready = (state == S_WAIT_RESULT);
  assign exp_index    = vec_ptr;

  // Watchdog: restarts at each issue and at the accept handshake, counts while waiting.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wd <= '0;
    end else if ((state == S_ISSUE) || accept_hs) begin
      wd <= '0;
    end else if (in_wait) begin
      wd <= wd + WD_W'(1);
    end
  end

  // Run sequencing, result scoring and status outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= S_IDLE;
      vec_ptr     <= 3'd0;
      next_test   <= 1'b0;
      test_index  <= 3'd0;
      err_count   <= 4'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      next_test <= 1'b0;
      if (wd_expire) begin
        // The generator already advanced past this vector, so keep vec_ptr in step.
        state       <= S_DONE;
        vec_ptr     <= vec_ptr + 3'd1;
        err_count   <= err_inc;
        timeout_err <= 1'b1;
        busy        <= 1'b0;
        done        <= 1'b1;
        pass        <= 1'b0;
      end else begin
        case (state)
          S_IDLE, S_DONE: begin
            if (start) begin
              state       <= S_ISSUE;
              next_test   <= 1'b1;
              busy        <= 1'b1;
              test_index  <= 3'd0;
              err_count   <= 4'd0;
              timeout_err <= 1'b0;
              done        <= 1'b0;
              pass        <= 1'b0;
            end
          end
          S_ISSUE: begin
            state <= S_WAIT_ACCEPT;
          end
          S_WAIT_ACCEPT: begin
            if (accept_hs) begin
              state <= S_WAIT_RESULT;
            end
          end
          S_WAIT_RESULT: begin
            if (result_hs) begin
              vec_ptr <= vec_ptr + 3'd1;
              if (mismatch) begin
                err_count <= err_inc;
              end
              if (test_index == LAST_IDX) begin
                state <= S_DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
                pass  <= !mismatch && (err_count == 4'd0);
              end else begin
                state      <= S_ISSUE;
                next_test  <= 1'b1;
                test_index <= test_index + 3'd1;
              end
            end
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
